// File: rtl/stopwatch_counter_pkg.sv
// Shared types and helpers for the centisecond stopwatch: state encoding and prescaler sizing.
package stopwatch_counter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_SAT   = 2'd3
    } state_t;

    // Clock cycles per count increment.
    function automatic int unsigned div_of(input int unsigned clk_freq, input int unsigned tick_freq);
        return clk_freq / tick_freq;
    endfunction

    // Prescaler register width; at least one bit even for a divide-by-one.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Button inputs and display outputs of the stopwatch, bundled for the board-side and core-side views.
interface stopwatch_counter_if #(
    parameter int unsigned BIT_SIZE = 20
);
    logic                start_stop;
    logic                clear;
    logic                lap;
    logic [BIT_SIZE-1:0] number;
    logic                running;
    logic                overflow;
    logic                lap_active;

    modport master (
        output start_stop, clear, lap,
        input  number, running, overflow, lap_active
    );

    modport slave (
        input  start_stop, clear, lap,
        output number, running, overflow, lap_active
    );
endinterface

// File: rtl/stopwatch_counter_btn_edge_sync.sv
// Raw pushbutton -> 2-FF synchronizer -> rising-edge detect; one single-cycle pulse per press.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse_c
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_c = sync_q[1] & ~prev_q;
endmodule

// File: rtl/stopwatch_counter.sv
// Centisecond stopwatch core: start/stop, clear, saturation at MAX_COUNT.
// Optional lap freeze of the displayed value when LAP_HOLD_EN is defined.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int unsigned BIT_SIZE  = 20,
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned TICK_FREQ = 100,
    parameter int unsigned MAX_COUNT = 999_999
) (
    input  logic              clk,
    input  logic              rst,
    stopwatch_counter_if.slave bus
);
    localparam int unsigned DIV     = div_of(CLK_FREQ, TICK_FREQ);
    localparam int unsigned PRESC_W = presc_width(DIV);

    logic ss_c;
    logic clear_c;
    logic tick_c;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [BIT_SIZE-1:0]  count_q, count_d;
    logic [BIT_SIZE-1:0]  number_q, number_d;
    logic                 running_q, overflow_q;

    btn_edge_sync u_ss_sync    (.clk(clk), .rst(rst), .btn(bus.start_stop), .pulse_c(ss_c));
    btn_edge_sync u_clear_sync (.clk(clk), .rst(rst), .btn(bus.clear),      .pulse_c(clear_c));

`ifdef LAP_HOLD_EN
    logic                lap_c;
    logic                lap_active_q, lap_active_d;
    logic [BIT_SIZE-1:0] lap_reg_q, lap_reg_d;

    btn_edge_sync u_lap_sync (.clk(clk), .rst(rst), .btn(bus.lap), .pulse_c(lap_c));
`else
    logic unused_lap;
    assign unused_lap = bus.lap;
`endif

    assign tick_c = (state_q == S_RUN) && (presc_q == PRESC_W'(DIV - 1));

    // Next-state, prescaler, count and display value; clear overrides everything.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
`ifdef LAP_HOLD_EN
        lap_active_d = lap_active_q;
        lap_reg_d    = lap_reg_q;
`endif

        if (state_q == S_RUN) begin
            presc_d = tick_c ? '0 : presc_q + 1'b1;
        end
        if (tick_c) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            S_IDLE:  if (ss_c) state_d = S_RUN;
            S_RUN: begin
                if (tick_c && (count_q == BIT_SIZE'(MAX_COUNT - 1))) state_d = S_SAT;
                else if (ss_c)                                         state_d = S_PAUSE;
            end
            S_PAUSE: if (ss_c) state_d = S_RUN;
            S_SAT:   state_d = S_SAT;
            default: state_d = S_IDLE;
        endcase

`ifdef LAP_HOLD_EN
        if (lap_c && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
            lap_active_d = ~lap_active_q;
            if (!lap_active_q) lap_reg_d = count_q;
        end
`endif

        if (clear_c) begin
            state_d = S_IDLE;
            presc_d = '0;
            count_d = '0;
`ifdef LAP_HOLD_EN
            lap_active_d = 1'b0;
`endif
        end

`ifdef LAP_HOLD_EN
        number_d = lap_active_d ? lap_reg_d : count_d;
`else
        number_d = count_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            number_q   <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            number_q   <= number_d;
            running_q  <= (state_d == S_RUN);
            overflow_q <= (state_d == S_SAT);
        end
    end

`ifdef LAP_HOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_active_q <= 1'b0;
            lap_reg_q    <= '0;
        end else begin
            lap_active_q <= lap_active_d;
            lap_reg_q    <= lap_reg_d;
        end
    end

    assign bus.lap_active = lap_active_q;
`else
    assign bus.lap_active = 1'b0;
`endif

    assign bus.number   = number_q;
    assign bus.running  = running_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: a run-time based reference model predicts every cycle's outputs.
module tb_stopwatch_counter;
    localparam int unsigned BW   = 20;
    localparam int unsigned DIV  = 10;
    localparam int unsigned MAXC = 25;

    logic clk = 1'b0;
    logic rst;

    stopwatch_counter_if #(.BIT_SIZE(BW)) bus ();

    stopwatch_counter #(
        .BIT_SIZE (BW),
        .CLK_FREQ (10),
        .TICK_FREQ(1),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] number;
        logic          running;
        logic          overflow;
        logic          lap_active;
    } exp_t;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_SAT} mode_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: displayed count is run-time-in-RUN divided by DIV; buttons act 3 edges after rising.
    mode_t       m_mode;
    int unsigned m_run_clk;
    logic        m_lap_on;
    int unsigned m_lap_val;
    logic [2:0]  h_ss, h_clr, h_lap;

    always @(posedge clk) begin
        logic p_ss, p_clr, p_lap;
        exp_t e;
        int unsigned shown;
        if (!rst) begin
            m_mode = M_IDLE; m_run_clk = 0; m_lap_on = 1'b0; m_lap_val = 0;
            h_ss = 3'b000; h_clr = 3'b000; h_lap = 3'b000;
        end else begin
            p_ss  = h_ss[1]  & ~h_ss[2];
            p_clr = h_clr[1] & ~h_clr[2];
            p_lap = h_lap[1] & ~h_lap[2];
            h_ss  = {h_ss[1:0],  bus.start_stop};
            h_clr = {h_clr[1:0], bus.clear};
            h_lap = {h_lap[1:0], bus.lap};
            if (p_clr) begin
                m_mode = M_IDLE; m_run_clk = 0; m_lap_on = 1'b0;
            end else begin
`ifdef LAP_HOLD_EN
                if (p_lap && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
                    if (!m_lap_on) m_lap_val = m_run_clk / DIV;
                    m_lap_on = ~m_lap_on;
                end
`endif
                case (m_mode)
                    M_RUN: begin
                        m_run_clk++;
                        if (m_run_clk / DIV >= MAXC) m_mode = M_SAT;
                        else if (p_ss)               m_mode = M_PAUSE;
                    end
                    M_IDLE, M_PAUSE: if (p_ss) m_mode = M_RUN;
                    default: ;
                endcase
            end
            shown = m_run_clk / DIV;
            if (shown > MAXC) shown = MAXC;
            e.number     = BW'(m_lap_on ? m_lap_val : shown);
            e.running    = (m_mode == M_RUN);
            e.overflow   = (m_mode == M_SAT);
            e.lap_active = m_lap_on;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("number",     32'(bus.number),     32'(e.number));
            chk("running",    32'(bus.running),    32'(e.running));
            chk("overflow",   32'(bus.overflow),   32'(e.overflow));
            chk("lap_active", 32'(bus.lap_active), 32'(e.lap_active));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_btns(input logic ss, input logic clr, input logic lp, input int hold);
        @(negedge clk);
        bus.start_stop = ss; bus.clear = clr; bus.lap = lp;
        repeat (hold) @(negedge clk);
        bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
        wait_cyc(3);
        #1;
        chk("reset_number",     32'(bus.number),     0);
        chk("reset_running",    32'(bus.running),    0);
        chk("reset_overflow",   32'(bus.overflow),   0);
        chk("reset_lap_active", 32'(bus.lap_active), 0);
        #1 rst = 1'b1;

        // Async reset in the middle of a run (count 7).
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(76);
        chk("pre_reset_number", 32'(bus.number), 7);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_number",  32'(bus.number),  0);
        chk("async_rst_running", 32'(bus.running), 0);
        wait_cyc(2);
        #2 rst = 1'b1;
        wait_cyc(5);

        // Start and count; then a long hold yields a single pause.
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(50);
        pulse_btns(1'b1, 1'b0, 1'b0, 40);
        wait_cyc(20);

        // Pause with a partial prescaler period, then resume.
        pulse_btns(1'b0, 1'b1, 1'b0, 1);
        wait_cyc(5);
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(5);
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(10);
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(30);

        // Run to saturation; start_stop ignored; clear recovers.
        pulse_btns(1'b0, 1'b1, 1'b0, 1);
        wait_cyc(5);
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(270);
        #1;
        chk("sat_number",   32'(bus.number),   MAXC);
        chk("sat_overflow", 32'(bus.overflow), 1);
        chk("sat_running",  32'(bus.running),  0);
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(10);
        pulse_btns(1'b0, 1'b1, 1'b0, 1);
        wait_cyc(5);
        #1;
        chk("clr_number",   32'(bus.number),   0);
        chk("clr_overflow", 32'(bus.overflow), 0);

        // Clear and start_stop together while running.
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(20);
        pulse_btns(1'b1, 1'b1, 1'b0, 1);
        wait_cyc(5);
        #1;
        chk("clr_ss_number",  32'(bus.number),  0);
        chk("clr_ss_running", 32'(bus.running), 0);

        // Lap freeze and release.
        pulse_btns(1'b1, 1'b0, 1'b0, 1);
        wait_cyc(52);
        pulse_btns(1'b0, 1'b0, 1'b1, 1);
        wait_cyc(30);
        pulse_btns(1'b0, 1'b0, 1'b1, 1);
        wait_cyc(20);
        pulse_btns(1'b0, 1'b1, 1'b0, 1);
        wait_cyc(5);

        // Randomized button activity.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) bus.start_stop = ~bus.start_stop;
            if ($urandom_range(0, 39) == 0) bus.lap = ~bus.lap;
            if (bus.clear) bus.clear = 1'b0;
            else if ($urandom_range(0, 499) == 0) bus.clear = 1'b1;
        end
        bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
        wait_cyc(5);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
